// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// Expiry either parks at zero (one-shot) or reloads the captured start value (periodic).
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             tc_q, tc_nxt;

  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      tc_q     <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_nxt = dec(count_q);
            end else if (count_q == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = reload_q;
              end else begin
                count_nxt = '0;
                state_nxt = DONE;
              end
            end else begin
              // A zero count in RUN cannot be reached; fall back to IDLE rather than wrap.
              state_nxt = IDLE;
            end
          end
        end
        IDLE, DONE: count_nxt = '0;
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == RUN);
  assign zero     = (count_q == '0);
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand sequences for long corners,
// then randomized traffic against an integer reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       auto_reload = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       zero;
  logic       tc_pulse;

  int passed = 0;
  int total  = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .count(count), .busy(busy), .zero(zero),
    .tc_pulse(tc_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, l, e, a;
    logic [3:0] lv;
    logic [3:0] ecnt;
    logic       ebusy, etc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic e, input logic a,
                     input int lv, input int c, input logic b, input logic t);
    vec_t v;
    v.r = r; v.l = l; v.e = e; v.a = a;
    v.lv = 4'(lv); v.ecnt = 4'(c); v.ebusy = b; v.etc = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic a,
                      input logic [3:0] lv);
    rst = r; load = l; en = e; auto_reload = a; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input logic b, input logic t);
    chk({tag, ".count"}, count, c);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".zero"}, zero, (c == 0));
    chk({tag, ".tc"}, tc_pulse, t);
  endtask

  // Reference model: remaining ticks, stored period, running flag.
  int  m_cnt, m_per;
  bit  m_run, m_tc;

  task automatic model_step(input logic r, input logic l, input logic e, input logic a,
                            input int lv);
    m_tc = 0;
    if (r) begin
      m_cnt = 0; m_per = 0; m_run = 0;
    end else if (l) begin
      m_cnt = lv; m_per = lv; m_run = (lv != 0);
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (a) m_cnt = m_per;
        else begin
          m_cnt = 0; m_run = 0;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic       r_r, r_l, r_e, r_a;
    logic [3:0] r_lv;

    // Reset held with load/en asserted, then idle enables
    add(1,1,1,0,5, 0,0,0); add(1,1,1,0,5, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1,0,0, 0,0,0);
    // One-shot from 5
    add(0,1,0,0,5, 5,1,0);
    for (int c = 4; c >= 1; c--) add(0,0,1,0,0, c,1,0);
    add(0,0,1,0,0, 0,0,1);
    for (int i = 0; i < 4; i++) add(0,0,1,0,0, 0,0,0);
    // Enable gating from 4
    add(0,1,0,0,4, 4,1,0);
    add(0,0,1,0,0, 3,1,0); add(0,0,0,0,0, 3,1,0); add(0,0,0,0,0, 3,1,0);
    add(0,0,1,0,0, 2,1,0); add(0,0,1,0,0, 1,1,0); add(0,0,1,0,0, 0,0,1);
    // Periodic with reload 3
    add(0,1,0,1,3, 3,1,0);
    for (int k = 1; k <= 9; k++)
      add(0,0,1,1,0, (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0));
    // Load on the expiry edge wins, then load of zero
    add(0,0,1,1,0, 2,1,0); add(0,0,1,1,0, 1,1,0);
    add(0,1,1,1,7, 7,1,0);
    add(0,1,1,0,0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].a, vecs[i].lv);
      chk_all($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].ebusy, vecs[i].etc);
    end

    // Max load: pulse exactly 15 enabled cycles after load
    step(0,1,0,0,4'd15);
    chk_all("max.load", 15, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      step(0,0,1,0,4'd0);
      chk_all($sformatf("max.c%0d", i), 15 - i, (i < 15), (i == 15));
    end

    // Reset mid-run
    step(0,1,0,0,4'd9);
    chk_all("rmr.load", 9, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0,0,1,0,4'd0);
      chk_all($sformatf("rmr.c%0d", i), 9 - i, 1, 0);
    end
    step(1,0,1,0,4'd0);
    chk_all("rmr.rst", 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0,0,1,0,4'd0);
      chk_all($sformatf("rmr.idle%0d", i), 0, 0, 0);
    end

    // Randomized traffic against the reference model
    step(1,0,0,0,4'd0);
    model_step(1,0,0,0,0);
    for (int i = 0; i < 300; i++) begin
      r_r  = ($urandom_range(0, 39) == 0);
      r_l  = ($urandom_range(0, 7) == 0);
      r_e  = ($urandom_range(0, 3) != 0);
      r_a  = $urandom_range(0, 1);
      r_lv = 4'($urandom_range(0, 15));
      step(r_r, r_l, r_e, r_a, r_lv);
      model_step(r_r, r_l, r_e, r_a, r_lv);
      chk_all($sformatf("rnd%0d", i), m_cnt, m_run, m_tc);
    end

    $display("SUMMARY: %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
